// File: rtl/ddr4_rd_return.sv
// Read-return stage behind the DFI read interface: packs phase words into BL8 bursts,
// pairs each burst with the oldest outstanding read tag and meters command issue with credits.
module ddr4_rd_return #(
    parameter int DFI_DATA_WIDTH        = 128,
    parameter int DFI_DATA_ENABLE_WIDTH = 16,
    parameter int TAG_WIDTH             = 4,
    parameter int BURST_DEPTH           = 8
) (
    input  logic                                dfi_clk,
    input  logic                                reset,
    input  logic                                cmd_rd_valid,
    input  logic [TAG_WIDTH-1:0]                cmd_rd_tag,
    output logic                                cmd_rd_ready,
    input  logic [DFI_DATA_WIDTH-1:0]           dfi_rddata_w0,
    input  logic [DFI_DATA_WIDTH-1:0]           dfi_rddata_w1,
    input  logic [DFI_DATA_WIDTH-1:0]           dfi_rddata_w2,
    input  logic [DFI_DATA_WIDTH-1:0]           dfi_rddata_w3,
    input  logic [DFI_DATA_ENABLE_WIDTH-1:0]    dfi_rddata_valid_w0,
    input  logic [DFI_DATA_ENABLE_WIDTH-1:0]    dfi_rddata_valid_w1,
    input  logic [DFI_DATA_ENABLE_WIDTH-1:0]    dfi_rddata_valid_w2,
    input  logic [DFI_DATA_ENABLE_WIDTH-1:0]    dfi_rddata_valid_w3,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [4*DFI_DATA_WIDTH-1:0]         rd_data,
    output logic [TAG_WIDTH-1:0]                rd_tag,
    output logic [$clog2(BURST_DEPTH):0]        outstanding,
    output logic                                err_orphan,
    output logic                                err_valid_mismatch
);
    localparam int W  = DFI_DATA_WIDTH;
    localparam int AW = $clog2(BURST_DEPTH);
    localparam int OW = AW + 1;

    logic [W-1:0]          w_ph_data [4];
    logic [3:0]            w_ph_vld;
    logic [3:0]            w_ph_bad;

    logic [W-1:0]          r_acc [3];
    logic [1:0]            r_acc_cnt;
    logic [W-1:0]          w_words [8];
    logic [2:0]            w_total;
    logic                  w_done;
    logic [4*W-1:0]        w_burst;

    logic [TAG_WIDTH-1:0]  r_tag_mem [BURST_DEPTH];
    logic [AW:0]           r_tag_wp;
    logic [AW:0]           r_tag_rp;
    logic                  w_tag_empty;
    logic                  w_cmd_acc;
    logic                  w_tag_pop;
    logic [TAG_WIDTH-1:0]  w_pair_tag;

    logic [4*W-1:0]        r_bst_data [BURST_DEPTH];
    logic [TAG_WIDTH-1:0]  r_bst_tag  [BURST_DEPTH];
    logic [AW:0]           r_bst_wp;
    logic [AW:0]           r_bst_rp;
    logic                  w_bst_empty;
    logic                  w_bst_pop;
    logic                  w_out_dec;

    logic [OW-1:0]         r_out;
    logic                  r_err_orphan;
    logic                  r_err_vm;

    assign w_ph_data[0] = dfi_rddata_w0;
    assign w_ph_data[1] = dfi_rddata_w1;
    assign w_ph_data[2] = dfi_rddata_w2;
    assign w_ph_data[3] = dfi_rddata_w3;

    // A phase counts only when every enable bit is set; any partial enable is an error.
    assign w_ph_vld = {&dfi_rddata_valid_w3, &dfi_rddata_valid_w2,
                       &dfi_rddata_valid_w1, &dfi_rddata_valid_w0};
    assign w_ph_bad = {(|dfi_rddata_valid_w3) & ~(&dfi_rddata_valid_w3),
                       (|dfi_rddata_valid_w2) & ~(&dfi_rddata_valid_w2),
                       (|dfi_rddata_valid_w1) & ~(&dfi_rddata_valid_w1),
                       (|dfi_rddata_valid_w0) & ~(&dfi_rddata_valid_w0)};

    always_comb begin
        for (int i = 0; i < 8; i++) w_words[i] = '0;
        for (int i = 0; i < 3; i++) w_words[i] = r_acc[i];
        w_total = {1'b0, r_acc_cnt};
        for (int p = 0; p < 4; p++) begin
            if (w_ph_vld[p]) begin
                w_words[w_total] = w_ph_data[p];
                w_total          = w_total + 3'd1;
            end
        end
    end

    // Total never exceeds 7, so bit 2 alone marks a completed burst and bits 1:0 are the carry.
    assign w_done  = w_total[2];
    assign w_burst = {w_words[3], w_words[2], w_words[1], w_words[0]};

    assign w_cmd_acc   = cmd_rd_valid & cmd_rd_ready;
    assign w_tag_empty = (r_tag_wp == r_tag_rp);
    assign w_tag_pop   = w_done & ~w_tag_empty;
    assign w_pair_tag  = w_tag_empty ? '0 : r_tag_mem[r_tag_rp[AW-1:0]];

    assign w_bst_empty = (r_bst_wp == r_bst_rp);
    assign w_bst_pop   = rd_valid & rd_ready;
    assign w_out_dec   = w_bst_pop & (r_out != '0);

    assign rd_valid           = ~w_bst_empty;
    assign rd_data            = rd_valid ? r_bst_data[r_bst_rp[AW-1:0]] : '0;
    assign rd_tag             = rd_valid ? r_bst_tag[r_bst_rp[AW-1:0]]  : '0;
    assign cmd_rd_ready       = (r_out < OW'(BURST_DEPTH));
    assign outstanding        = r_out;
    assign err_orphan         = r_err_orphan;
    assign err_valid_mismatch = r_err_vm;

    always_ff @(posedge dfi_clk) begin
        if (reset) begin
            r_acc_cnt    <= '0;
            r_tag_wp     <= '0;
            r_tag_rp     <= '0;
            r_bst_wp     <= '0;
            r_bst_rp     <= '0;
            r_out        <= '0;
            r_err_orphan <= 1'b0;
            r_err_vm     <= 1'b0;
        end else begin
            r_acc_cnt <= w_total[1:0];
            if (w_cmd_acc) r_tag_wp <= r_tag_wp + 1'b1;
            if (w_tag_pop) r_tag_rp <= r_tag_rp + 1'b1;
            if (w_done)    r_bst_wp <= r_bst_wp + 1'b1;
            if (w_bst_pop) r_bst_rp <= r_bst_rp + 1'b1;
            r_out <= r_out + {{(OW-1){1'b0}}, w_cmd_acc} - {{(OW-1){1'b0}}, w_out_dec};
            if (w_done && w_tag_empty) r_err_orphan <= 1'b1;
            if (|w_ph_bad)             r_err_vm     <= 1'b1;
        end
    end

    // Storage is left unreset: pointers and counts alone decide what is visible.
    always_ff @(posedge dfi_clk) begin
        for (int i = 0; i < 3; i++) r_acc[i] <= w_done ? w_words[i+4] : w_words[i];
        if (w_cmd_acc) r_tag_mem[r_tag_wp[AW-1:0]] <= cmd_rd_tag;
        if (w_done) begin
            r_bst_data[r_bst_wp[AW-1:0]] <= w_burst;
            r_bst_tag[r_bst_wp[AW-1:0]]  <= w_pair_tag;
        end
    end
endmodule

// File: tb/tb_ddr4_rd_return.sv
// Bench for ddr4_rd_return: directed scenarios plus a randomized run against a queue-based model.
module tb_ddr4_rd_return;
    logic         dfi_clk = 1'b0;
    logic         reset;
    logic         cmd_rd_valid;
    logic [3:0]   cmd_rd_tag;
    logic         cmd_rd_ready;
    logic [127:0] ph_d [4];
    logic [15:0]  ph_v [4];
    logic         rd_valid;
    logic         rd_ready;
    logic [511:0] rd_data;
    logic [3:0]   rd_tag;
    logic [3:0]   outstanding;
    logic         err_orphan;
    logic         err_valid_mismatch;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [511:0] data;
        logic [3:0]   tag;
    } burst_t;

    logic [127:0] m_words[$];
    logic [3:0]   m_tags[$];
    burst_t       m_bursts[$];
    int           m_out;
    bit           m_orphan;
    bit           m_vm;

    ddr4_rd_return dut (
        .dfi_clk            (dfi_clk),
        .reset              (reset),
        .cmd_rd_valid       (cmd_rd_valid),
        .cmd_rd_tag         (cmd_rd_tag),
        .cmd_rd_ready       (cmd_rd_ready),
        .dfi_rddata_w0      (ph_d[0]),
        .dfi_rddata_w1      (ph_d[1]),
        .dfi_rddata_w2      (ph_d[2]),
        .dfi_rddata_w3      (ph_d[3]),
        .dfi_rddata_valid_w0(ph_v[0]),
        .dfi_rddata_valid_w1(ph_v[1]),
        .dfi_rddata_valid_w2(ph_v[2]),
        .dfi_rddata_valid_w3(ph_v[3]),
        .rd_valid           (rd_valid),
        .rd_ready           (rd_ready),
        .rd_data            (rd_data),
        .rd_tag             (rd_tag),
        .outstanding        (outstanding),
        .err_orphan         (err_orphan),
        .err_valid_mismatch (err_valid_mismatch)
    );

    always #5 dfi_clk = ~dfi_clk;

    function automatic logic [127:0] rword();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_phases();
        for (int p = 0; p < 4; p++) begin
            ph_v[p] = '0;
            ph_d[p] = '0;
        end
    endtask

    task automatic set_phases(input logic [3:0] mask);
        for (int p = 0; p < 4; p++) begin
            ph_v[p] = mask[p] ? 16'hFFFF : 16'h0000;
            ph_d[p] = rword();
        end
    endtask

    // One clock: the model takes the same inputs the DUT samples at this edge.
    task automatic step();
        bit acc;
        bit del;
        burst_t b;
        acc = cmd_rd_valid && (m_out < 8);
        del = rd_ready && (m_bursts.size() > 0);
        @(posedge dfi_clk);
        if (reset) begin
            m_words.delete();
            m_tags.delete();
            m_bursts.delete();
            m_out = 0;
            m_orphan = 0;
            m_vm = 0;
        end else begin
            if (del) begin
                void'(m_bursts.pop_front());
                if (m_out > 0) m_out--;
            end
            for (int p = 0; p < 4; p++) begin
                if (ph_v[p] == 16'hFFFF) m_words.push_back(ph_d[p]);
                else if (ph_v[p] != 16'h0000) m_vm = 1;
            end
            if (m_words.size() >= 4) begin
                b.data = {m_words[3], m_words[2], m_words[1], m_words[0]};
                for (int k = 0; k < 4; k++) void'(m_words.pop_front());
                if (m_tags.size() > 0) b.tag = m_tags.pop_front();
                else begin
                    b.tag = 4'h0;
                    m_orphan = 1;
                end
                m_bursts.push_back(b);
            end
            if (acc) begin
                m_tags.push_back(cmd_rd_tag);
                m_out++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_rd_valid = 1'b0;
        rd_ready = 1'b0;
        idle_phases();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%0d exp=0", rd_valid); end
        checks++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_tag !== 4'h0) begin fails++; $display("FAIL reset_rd_tag got=%0h exp=0", rd_tag); end
        checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (cmd_rd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got=%0d exp=1", cmd_rd_ready); end
        checks++; if ({err_orphan, err_valid_mismatch} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b exp=00", {err_orphan, err_valid_mismatch}); end
    endtask

    task automatic test_aligned();
        logic [511:0] exp;
        cmd_rd_valid = 1'b1; cmd_rd_tag = 4'h3;
        step();
        cmd_rd_valid = 1'b0;
        checks++; if (outstanding !== 4'd1) begin fails++; $display("FAIL aligned_out1 got=%0d exp=1", outstanding); end
        set_phases(4'b1111);
        exp = {ph_d[3], ph_d[2], ph_d[1], ph_d[0]};
        step();
        idle_phases();
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL aligned_valid got=%0d exp=1", rd_valid); end
        checks++; if (rd_data !== exp) begin fails++; $display("FAIL aligned_data got=%h exp=%h", rd_data, exp); end
        checks++; if (rd_tag !== 4'h3) begin fails++; $display("FAIL aligned_tag got=%0h exp=3", rd_tag); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL aligned_out0 got=%0d exp=0", outstanding); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL aligned_drained got=%0d exp=0", rd_valid); end
    endtask

    task automatic test_misaligned();
        logic [127:0] a, b;
        logic [511:0] exp;
        cmd_rd_valid = 1'b1; cmd_rd_tag = 4'h5;
        step();
        cmd_rd_valid = 1'b0;
        set_phases(4'b1100);
        a = ph_d[2]; b = ph_d[3];
        step();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL misal_early got=%0d exp=0", rd_valid); end
        set_phases(4'b0011);
        exp = {ph_d[1], ph_d[0], b, a};
        step();
        idle_phases();
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL misal_valid got=%0d exp=1", rd_valid); end
        checks++; if (rd_data !== exp) begin fails++; $display("FAIL misal_data got=%h exp=%h", rd_data, exp); end
        checks++; if (rd_tag !== 4'h5) begin fails++; $display("FAIL misal_tag got=%0h exp=5", rd_tag); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL misal_residue got=%0d exp=0", rd_valid); end
    endtask

    task automatic test_mixed();
        logic [127:0] w[8];
        logic [511:0] exp1, exp2;
        cmd_rd_valid = 1'b1; cmd_rd_tag = 4'h1;
        step();
        cmd_rd_tag = 4'h2;
        step();
        cmd_rd_valid = 1'b0;
        set_phases(4'b0111);
        w[0] = ph_d[0]; w[1] = ph_d[1]; w[2] = ph_d[2];
        step();
        set_phases(4'b1110);
        w[3] = ph_d[1]; w[4] = ph_d[2]; w[5] = ph_d[3];
        step();
        exp1 = {w[3], w[2], w[1], w[0]};
        checks++; if (rd_data !== exp1 || rd_tag !== 4'h1) begin fails++; $display("FAIL mixed_first got=%h/%0h exp=%h/1", rd_data, rd_tag, exp1); end
        set_phases(4'b1010);
        w[6] = ph_d[1]; w[7] = ph_d[3];
        step();
        idle_phases();
        checks++; if (rd_data !== exp1) begin fails++; $display("FAIL mixed_hold got=%h exp=%h", rd_data, exp1); end
        rd_ready = 1'b1;
        step();
        exp2 = {w[7], w[6], w[5], w[4]};
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp2 || rd_tag !== 4'h2) begin fails++; $display("FAIL mixed_second got=%0d/%h/%0h exp=1/%h/2", rd_valid, rd_data, rd_tag, exp2); end
        step();
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || outstanding !== 4'd0) begin fails++; $display("FAIL mixed_drain got=%0d/%0d exp=0/0", rd_valid, outstanding); end
    endtask

    task automatic test_credit();
        logic [511:0] exp[9];
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd_rd_valid = 1'b1; cmd_rd_tag = 4'(i);
            step();
        end
        cmd_rd_valid = 1'b0;
        checks++; if (cmd_rd_ready !== 1'b0 || outstanding !== 4'd8) begin fails++; $display("FAIL credit_full got=%0d/%0d exp=0/8", cmd_rd_ready, outstanding); end
        for (int i = 0; i < 8; i++) begin
            set_phases(4'b1111);
            exp[i] = {ph_d[3], ph_d[2], ph_d[1], ph_d[0]};
            step();
        end
        // Full burst FIFO: pop and an orphan completion land on the same edge.
        rd_ready = 1'b1;
        set_phases(4'b1111);
        exp[8] = {ph_d[3], ph_d[2], ph_d[1], ph_d[0]};
        step();
        rd_ready = 1'b0;
        idle_phases();
        checks++; if (cmd_rd_ready !== 1'b1 || outstanding !== 4'd7) begin fails++; $display("FAIL credit_release got=%0d/%0d exp=1/7", cmd_rd_ready, outstanding); end
        checks++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL credit_orphan got=%0d exp=1", err_orphan); end
        rd_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp[i] || rd_tag !== ((i < 8) ? 4'(i) : 4'h0)) begin
                fails++;
                $display("FAIL credit_drain%0d got=%0d/%0h", i, rd_valid, rd_tag);
            end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || outstanding !== 4'd0) begin fails++; $display("FAIL credit_sat got=%0d/%0d exp=0/0", rd_valid, outstanding); end
        do_reset();
    endtask

    task automatic test_errors();
        logic [511:0] exp;
        logic [127:0] y1, y2, y3;
        set_phases(4'b1111);
        exp = {ph_d[3], ph_d[2], ph_d[1], ph_d[0]};
        step();
        idle_phases();
        checks++; if (err_orphan !== 1'b1 || rd_tag !== 4'h0 || rd_data !== exp) begin fails++; $display("FAIL orphan got=%0d/%0h exp=1/0", err_orphan, rd_tag); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL orphan_out got=%0d exp=0", outstanding); end
        set_phases(4'b1111);
        ph_v[0] = 16'h00FF;
        y1 = ph_d[1]; y2 = ph_d[2]; y3 = ph_d[3];
        step();
        checks++; if (err_valid_mismatch !== 1'b1 || rd_valid !== 1'b0) begin fails++; $display("FAIL vmis got=%0d/%0d exp=1/0", err_valid_mismatch, rd_valid); end
        set_phases(4'b0001);
        exp = {ph_d[0], y3, y2, y1};
        step();
        idle_phases();
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin fails++; $display("FAIL vmis_drop got=%h exp=%h", rd_data, exp); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp;
        cmd_rd_valid = 1'b1; cmd_rd_tag = 4'h9;
        step();
        cmd_rd_valid = 1'b0;
        set_phases(4'b0011);
        step();
        idle_phases();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (rd_valid !== 1'b0 || outstanding !== 4'd0 || cmd_rd_ready !== 1'b1) begin fails++; $display("FAIL rstmid got=%0d/%0d/%0d exp=0/0/1", rd_valid, outstanding, cmd_rd_ready); end
        cmd_rd_valid = 1'b1; cmd_rd_tag = 4'h6;
        step();
        cmd_rd_valid = 1'b0;
        set_phases(4'b1111);
        exp = {ph_d[3], ph_d[2], ph_d[1], ph_d[0]};
        step();
        idle_phases();
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp || rd_tag !== 4'h6) begin fails++; $display("FAIL rstmid_fresh got=%0d/%0h exp=1/6", rd_valid, rd_tag); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        int delivered = 0;
        int produced = 0;
        logic [3:0] mask;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cmd_rd_valid = ($urandom_range(0, 2) == 0);
            cmd_rd_tag = 4'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            mask = 4'($urandom);
            if (m_words.size() + $countones(mask) >= 4 && m_tags.size() == 0) mask = 4'b0000;
            set_phases(mask);
            if (rd_ready && m_bursts.size() > 0) delivered++;
            if (m_words.size() + $countones(mask) >= 4) produced++;
            step();
            checks++;
            if (rd_valid !== (m_bursts.size() > 0)) begin fails++; $display("FAIL rnd_valid c=%0d got=%0d exp=%0d", c, rd_valid, m_bursts.size() > 0); end
            else if (rd_valid && (rd_data !== m_bursts[0].data || rd_tag !== m_bursts[0].tag)) begin fails++; $display("FAIL rnd_burst c=%0d tag got=%0h exp=%0h", c, rd_tag, m_bursts[0].tag); end
            checks++;
            if (outstanding !== 4'(m_out) || cmd_rd_ready !== (m_out < 8)) begin fails++; $display("FAIL rnd_credit c=%0d got=%0d exp=%0d", c, outstanding, m_out); end
            checks++;
            if (err_orphan !== m_orphan || err_valid_mismatch !== m_vm) begin fails++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, {err_orphan, err_valid_mismatch}, {m_orphan, m_vm}); end
        end
        idle_phases();
        cmd_rd_valid = 1'b0;
        rd_ready = 1'b0;
        checks++;
        if (delivered < 50 || produced < delivered) begin fails++; $display("FAIL rnd_activity delivered=%0d produced=%0d", delivered, produced); end
    endtask

    initial begin
        reset = 1'b1;
        cmd_rd_valid = 1'b0;
        cmd_rd_tag = 4'h0;
        rd_ready = 1'b0;
        idle_phases();
        m_out = 0;
        m_orphan = 0;
        m_vm = 0;
        test_reset();
        test_aligned();
        test_misaligned();
        test_mixed();
        test_credit();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/ddr4_rd_return.md
Name: ddr4_rd_return

Overview:
- Read-return stage directly downstream of the DFI read data interface of the DDR4 controller (ddr4_op).
- Consumes the per-phase read words dfi_rddata_w0..w3 and their valids (4:1 frequency ratio), compacts them into complete BL8 bursts (4 phase words), and pairs each burst with the tag of the oldest outstanding read command.
- Presents bursts to the user side over a valid/ready handshake.
- Flow-controls read command issue with a credit scheme, because the PHY cannot be stalled.

Parameters:
- DFI_DATA_WIDTH, 128, width of one phase read word.
- DFI_DATA_ENABLE_WIDTH, 16, width of each dfi_rddata_valid_wN.
- TAG_WIDTH, 4, read command tag width.
- BURST_DEPTH, 8, burst FIFO depth; also the maximum number of outstanding reads (power of 2, ≥2).

Ports:
- dfi_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- cmd_rd_valid  in  1  read command issued to DRAM (from scheduler).
- cmd_rd_tag  in  TAG_WIDTH  tag of the issued read.
- cmd_rd_ready  out  1  credit available; the command is accepted when valid&ready.
- dfi_rddata_w0..w3  in  DFI_DATA_WIDTH each  PHY read words, phase 0..3.
- dfi_rddata_valid_w0..w3  in  DFI_DATA_ENABLE_WIDTH each  per-phase valid.
- rd_valid  out  1  burst available.
- rd_ready  in  1  user accepts the burst.
- rd_data  out  4*DFI_DATA_WIDTH  burst; [DFI_DATA_WIDTH-1:0] = first word received.
- rd_tag  out  TAG_WIDTH  tag paired with rd_data.
- outstanding  out  log2(BURST_DEPTH)+1  reads accepted but not yet delivered.
- err_orphan  out  1  sticky: a burst completed with the tag FIFO empty.
- err_valid_mismatch  out  1  sticky: a phase valid was neither all-ones nor all-zeros.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, rd_tag=0, outstanding=0, err_*=0, cmd_rd_ready=1. The accumulator, tag FIFO and burst FIFO are emptied.
- Reset asserted mid-operation discards all partial and queued data. The next cycle behaves as post-reset.
- Phase valid definition: phase N is valid when &dfi_rddata_valid_wN.
  - Any phase where |valid & ~&valid sets err_valid_mismatch. That phase is treated as invalid.
- Word ordering: each cycle, valid words are taken in ascending phase order (w0 first). Gaps between valid phases are skipped.
- Accumulator: holds 0-3 carried words plus 0-4 incoming words.
  - When the total reaches ≥4, the oldest 4 words form one burst, written to the burst FIFO at the end of that cycle.
  - The remainder (0-3 words) is carried to the next cycle.
  - At most one burst completes per cycle (maximum total is 7).
- Tag pairing:
  - cmd_rd_tag is pushed into the tag FIFO (depth BURST_DEPTH) on cmd_rd_valid&cmd_rd_ready.
  - On each burst completion the head tag is popped and stored alongside the burst.
  - A push and a pop in the same cycle are both honoured. A command accepted in cycle N can pair with a burst completing in cycle N+1 or later, not cycle N.
- Orphan burst: a completion with the tag FIFO empty sets err_orphan. The burst is still stored with tag 0.
- Latency: a burst completing in cycle N gives rd_valid=1 in cycle N+1 if the burst FIFO was empty. Otherwise it is delivered in FIFO order.
- rd_data and rd_tag are held stable while rd_valid&~rd_ready. A burst is popped on rd_valid&rd_ready.
  - Back-to-back delivery at one burst per cycle is required when rd_ready is held high.
- Credits:
  - outstanding increments on command acceptance and decrements on burst pop; both in the same cycle leaves it unchanged.
  - cmd_rd_ready = (outstanding < BURST_DEPTH), combinational from the registered count.
  - Consequence: the burst FIFO and tag FIFO never overflow in legal operation. No overflow path exists.
- Orphan pops: a pop of an orphan burst does not decrement below 0; outstanding saturates at 0.
- Boundaries:
  - Burst FIFO full with rd_ready=1 and a new completion in the same cycle: pop and push both occur.
  - Pointer wrap-around on both FIFOs is seamless.

Test Plan:
- Aligned burst: cmd tag 0x3, then all 4 phases valid in one cycle with words A,B,C,D → rd_valid next cycle, rd_data={D,C,B,A}, rd_tag=0x3, outstanding returns 1→0 on pop.
- Misaligned burst: valids 1100 (w2,w3 = A,B) in cycle N, then 0011 (w0,w1 = C,D) in N+1 → one burst {D,C,B,A} at N+2; no residue left in the accumulator.
- Mixed stream: two tags 0x1,0x2; valid counts 3,3,2 over three cycles → two bursts in order with tags 0x1 then 0x2; word order preserved across the carried remainder.
- Credit limit: issue 8 commands with rd_ready=0 → cmd_rd_ready=0 after the 8th. Deliver 8 bursts, then one rd_ready pulse → cmd_rd_ready=1 the following cycle.
- Errors: data burst with no commands → err_orphan=1, rd_tag=0. A phase valid of 0x00FF → err_valid_mismatch=1 and that word is dropped.
- Reset mid-burst: 2 words accumulated, then reset for 1 cycle → rd_valid=0, outstanding=0, cmd_rd_ready=1. A fresh aligned burst after reset is delivered intact.
